// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the two-writer / one-reader FIFO front end.
package fifo_arb_pkg;

    localparam int unsigned DW_DEFAULT     = 8;
    localparam int unsigned RD_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a write is accepted.
module rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    // last = 1 means requester 1 was granted most recently, so requester 0 wins a tie
    logic last;

    always_comb begin
        grant0 = req0 && (!req1 || last);
        grant1 = req1 && (!req0 || !last);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant1;
        end
    end

endmodule

// File: rtl/fifo_share_arb.sv
// Shares one FIFO write port between two requesters and drains the FIFO into a
// valid/ready consumer, one read in flight at a time.
module fifo_share_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr0_valid,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ready,
    input  logic          wr1_valid,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ready,
    output logic          fifo_write_n,
    output logic [DW-1:0] fifo_data_in,
    output logic          fifo_read_n,
    input  logic [DW-1:0] fifo_data_out,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic          rd_en,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    output logic          busy
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic grant0;
    logic grant1;
    logic accept;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req0   (wr0_valid),
        .req1   (wr1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        wr0_ready    = grant0 && !fifo_full && !reset;
        wr1_ready    = grant1 && !fifo_full && !reset;
        accept       = (wr0_valid && wr0_ready) || (wr1_valid && wr1_ready);
        fifo_write_n = !accept;
        fifo_data_in = grant1 ? wr1_data : wr0_data;
    end

    rd_state_t  state;
    rd_state_t  state_nx;
    logic [1:0] wait_cnt;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (rd_en && !fifo_empty) state_nx = RD_ISSUE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  if (wait_cnt == WAIT_LAST) state_nx = RD_HOLD;
            RD_HOLD:  if (tx_ready) state_nx = (rd_en && !fifo_empty) ? RD_ISSUE : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : '0;
            tx_valid <= (state_nx == RD_HOLD);
            // capture on the edge that closes the last wait cycle
            if (state == RD_WAIT && state_nx == RD_HOLD) begin
                tx_data <= fifo_data_out;
            end
        end
    end

    always_comb begin
        fifo_read_n = (state != RD_ISSUE);
        busy        = (state != IDLE);
    end

endmodule

// File: tb/tb_fifo_share_arb.sv
// Self-checking bench: behavioural FIFO environment, queue-based reference model, directed and random stimulus.
module tb_fifo_share_arb;

    localparam int unsigned RL       = 2;
    localparam int unsigned W        = 8;
    localparam int          DEPTH    = 8;
    localparam int          HOLD_AGE = int'(RL) + 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         wr0_valid = 1'b0;
    logic         wr1_valid = 1'b0;
    logic [W-1:0] wr0_data = '0;
    logic [W-1:0] wr1_data = '0;
    logic         wr0_ready;
    logic         wr1_ready;
    logic         fifo_write_n;
    logic [W-1:0] fifo_data_in;
    logic         fifo_read_n;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_full = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         rd_en = 1'b0;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fifo_share_arb #(.RD_LAT(RL), .DW(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr0_valid     (wr0_valid),
        .wr0_data      (wr0_data),
        .wr0_ready     (wr0_ready),
        .wr1_valid     (wr1_valid),
        .wr1_data      (wr1_data),
        .wr1_ready     (wr1_ready),
        .fifo_write_n  (fifo_write_n),
        .fifo_data_in  (fifo_data_in),
        .fifo_read_n   (fifo_read_n),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .rd_en         (rd_en),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO with registered flags and RL-cycle registered read data
    logic [W-1:0] env_q[$];
    logic [W-1:0] pipe [0:2];

    always @(posedge clock) begin : env_fifo
        logic [W-1:0] rd_val;
        if (!fifo_write_n) env_q.push_back(fifo_data_in);
        rd_val = W'($urandom);
        if (!fifo_read_n && env_q.size() > 0) rd_val = env_q.pop_front();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = rd_val;
        fifo_data_out <= pipe[RL-1];
        fifo_full     <= (env_q.size() >= DEPTH);
        fifo_empty    <= (env_q.size() == 0);
    end

    // Reference model: arbitration by "other one wins a tie", bytes in write order,
    // each read occupies issue + RL wait cycles before it is offered.
    int           m_last = 1;
    int           m_age = -1;
    logic [W-1:0] m_byte = '0;
    logic [W-1:0] m_tx_data = '0;
    logic [W-1:0] exp_q[$];
    bit           started = 1'b0;

    function automatic int winner(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clock) begin : model
        int w;
        if (reset) begin
            started   = 1'b1;
            m_last    = 1;
            m_age     = -1;
            m_tx_data = '0;
        end else begin
            w = fifo_full ? -1 : winner(wr0_valid, wr1_valid, m_last);
            if (w >= 0) begin
                exp_q.push_back(w == 0 ? wr0_data : wr1_data);
                m_last = w;
            end
            if (m_age < 0 || (m_age == HOLD_AGE && tx_ready)) begin
                if (rd_en && !fifo_empty) begin
                    m_age = 0;
                    if (exp_q.size() > 0) m_byte = exp_q.pop_front();
                end else begin
                    m_age = -1;
                end
            end else if (m_age < HOLD_AGE) begin
                m_age++;
                if (m_age == HOLD_AGE) m_tx_data = m_byte;
            end
        end
    end

    always @(negedge clock) begin : compare
        int w;
        if (started) begin
            w = (reset || fifo_full) ? -1 : winner(wr0_valid, wr1_valid, m_last);
            check("write_n", fifo_write_n, w < 0);
            if (w >= 0) check("data_in", fifo_data_in, (w == 0) ? wr0_data : wr1_data);
            if (wr0_valid || reset) check("wr0_ready", wr0_ready, w == 0);
            if (wr1_valid || reset) check("wr1_ready", wr1_ready, w == 1);
            check("read_n", fifo_read_n, m_age != 0);
            check("tx_valid", tx_valid, m_age == HOLD_AGE);
            check("tx_data", tx_data, m_tx_data);
            check("busy", busy, m_age >= 0);
            if (!fifo_read_n) check("read_while_empty", fifo_empty, 1'b0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W-1:0] exp_rr [4];
        int  pulses;
        bit  ok;
        bit  a0;
        bit  a1;

        exp_rr = '{8'h11, 8'h22, 8'h11, 8'h22};

        // reset with a pending writer: nothing may be accepted
        wr0_valid = 1'b1;
        wr0_data  = 8'hA5;
        repeat (2) cyc();
        #1;
        check("rst_wr0_ready", wr0_ready, 1'b0);
        check("rst_write_n", fifo_write_n, 1'b1);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_read_n", fifo_read_n, 1'b1);
        check("rst_busy", busy, 1'b0);

        // single byte through the read path
        cyc(); reset = 1'b0; rd_en = 1'b1; tx_ready = 1'b0; #1;
        check("first_accept", wr0_ready, 1'b1);
        check("first_write_n", fifo_write_n, 1'b0);
        check("first_data_in", fifo_data_in, 8'hA5);
        cyc(); wr0_valid = 1'b0; #1;
        check("idle_after_empty_fall", fifo_read_n, 1'b1);
        cyc(); #1;
        check("issue_pulse", fifo_read_n, 1'b0);
        cyc(); #1;
        check("issue_one_cycle", fifo_read_n, 1'b1);
        check("wait1_tx_valid", tx_valid, 1'b0);
        cyc(); #1;
        check("wait2_tx_valid", tx_valid, 1'b0);
        cyc(); #1;
        check("hold_tx_valid", tx_valid, 1'b1);
        check("hold_tx_data", tx_data, 8'hA5);

        // consumer stalls; a second byte arrives meanwhile but must not be read yet
        pulses = 0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 0) begin wr1_valid = 1'b1; wr1_data = 8'h3C; end
            if (i == 1) wr1_valid = 1'b0;
            #1;
            if (!fifo_read_n) pulses++;
            if (!tx_valid || tx_data !== 8'hA5) ok = 1'b0;
        end
        check("hold_stable", ok, 1'b1);
        check("hold_no_read", pulses, 0);
        cyc(); tx_ready = 1'b1; #1;
        cyc(); #1;
        check("reissue_after_handshake", fifo_read_n, 1'b0);
        for (int n = 0; n < 10; n++) begin
            cyc(); #1;
            if (tx_valid) break;
        end
        check("second_tx_valid", tx_valid, 1'b1);
        check("second_tx_data", tx_data, 8'h3C);
        rd_en = 1'b0;
        cyc();

        // tie-breaking: requester 1 was last, so 0,1,0,1
        cyc();
        wr0_valid = 1'b1; wr0_data = 8'h11;
        wr1_valid = 1'b1; wr1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_order", fifo_data_in, exp_rr[i]);
            if (i < 3) cyc();
        end
        cyc(); wr1_valid = 1'b0; wr0_data = 8'h5A; #1;
        check("solo_wr0_ready", wr0_ready, 1'b1);
        check("solo_write_n", fifo_write_n, 1'b0);
        check("solo_data_in", fifo_data_in, 8'h5A);
        cyc(); wr0_valid = 1'b0;

        // fill to full, then a blocked writer is released by a read
        wr1_valid = 1'b1; wr1_data = 8'h60;
        repeat (3) begin cyc(); wr1_data = wr1_data + 8'h01; end
        wr1_data = 8'h77; #1;
        check("full_wr1_ready", wr1_ready, 1'b0);
        check("full_write_n", fifo_write_n, 1'b1);
        cyc(); #1;
        check("full_wr1_ready_held", wr1_ready, 1'b0);
        rd_en = 1'b1; tx_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc(); #1;
            if (!fifo_full) break;
        end
        check("full_drop", fifo_full, 1'b0);
        check("release_wr1_ready", wr1_ready, 1'b1);
        check("release_write_n", fifo_write_n, 1'b0);
        check("release_data_in", fifo_data_in, 8'h77);
        cyc(); wr1_valid = 1'b0;
        repeat (60) cyc();

        // reset during the wait phase abandons the byte
        tx_ready = 1'b0; rd_en = 1'b1;
        wr0_valid = 1'b1; wr0_data = 8'h99;
        cyc(); wr0_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc(); #1;
            if (!fifo_read_n) break;
        end
        check("abort_issue_seen", fifo_read_n, 1'b0);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; rd_en = 1'b0; #1;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_read_n", fifo_read_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        ok = 1'b0;
        repeat (6) begin
            cyc(); #1;
            if (tx_valid) ok = 1'b1;
        end
        check("abort_no_late_valid", ok, 1'b0);

        // random traffic; writers hold their byte until accepted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            a0 = wr0_valid && wr0_ready;
            a1 = wr1_valid && wr1_ready;
            cyc();
            if (!wr0_valid || a0) begin
                wr0_valid = ($urandom_range(0, 99) < 55);
                wr0_data  = W'($urandom);
            end
            if (!wr1_valid || a1) begin
                wr1_valid = ($urandom_range(0, 99) < 55);
                wr1_data  = W'($urandom);
            end
            rd_en    = ($urandom_range(0, 99) < 75);
            tx_ready = ($urandom_range(0, 99) < 60);
            reset    = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
